// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: held word, per-frame flags and busy status.
// rx_valid rises when a frame commits and stays high, with rx_data and the flags
// stable, until a cycle where rx_ready is also high. That cycle transfers the word.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_break;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry holding register with overrun detection. FSM state is on dbg_state.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 14,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk_3125,
  input  logic              reset,
  input  logic              rx,
  uart_rx_param_if.master   rx_if,
  output logic [2:0]        dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           sync_q, sync_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 any_one_q, any_one_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_s;
  logic                 commit;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sync_d     = {sync_q[0], rx};
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    any_one_d  = any_one_q;
    commit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) begin
          state_d    = S_START;
          par_acc_d  = 1'b0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
          any_one_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          // A line back high at mid start bit is treated as noise.
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (MSB_FIRST != 0) shift_d = {shift_q[DATA_BITS-2:0], rx_s};
          else                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rx_s;
          any_one_d = any_one_q | rx_s;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_err_d = (par_acc_q ^ rx_s) != PAR_ODD;
          any_one_d = any_one_q | rx_s;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d      = '0;
          stop_err_d = stop_err_q | ~rx_s;
          any_one_d  = any_one_q | rx_s;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            commit  = 1'b1;
            // A low final stop sample means break or stuck line: wait for release.
            state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    valid_d = valid_q & ~rx_if.rx_ready;
    if (commit) begin
      data_d  = shift_q;
      perr_d  = par_err_q;
      ferr_d  = stop_err_q | ~rx_s;
      brk_d   = ~(any_one_q | rx_s);
      ovr_d   = valid_q & ~rx_if.rx_ready;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_3125) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sync_q     <= 2'b11;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      any_one_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sync_q     <= sync_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      any_one_q  <= any_one_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_parity_err = perr_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_break      = brk_q;
  assign rx_if.rx_overrun    = ovr_q;
  assign rx_if.rx_busy       = (state_q != S_IDLE);
  assign dbg_state           = state_q;

endmodule
